// File: rtl/ftoi_pipe.sv
// ftoi_pipe: three-stage pipelined IEEE-754 single-precision to integer converter.
// Four rounding modes, signed/unsigned targets, saturation with inexact/invalid
// flags, and an opaque tag carried alongside each operation.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready is combinational: adv)
//   in_x                IEEE-754 single operand
//   in_rm               00 RTZ, 01 floor, 10 ceil, 11 nearest-even
//   in_uns              1 = unsigned target, 0 = signed target
//   in_tag              opaque tag, returned unchanged on out_tag
//   out_valid/out_ready result handshake
//   out_y               converted integer (W bits)
//   out_nx, out_nv      inexact, invalid (NaN/Inf/out of range)
module ftoi_pipe #(
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [1:0]       in_rm,
  input  logic             in_uns,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_nx,
  output logic             out_nv
);

  // Shift amount is e-126 (unbiased exponent + 1 for the guard position), 0..W.
  localparam int unsigned SHW    = $clog2(W + 2);
  // Fixed-point view of the magnitude: W integer bits over 24 fraction bits.
  localparam int unsigned VW     = W + 24;
  localparam int unsigned E_LO   = 126;
  // Exponents at or above this give |x| >= 2^W (shift >= W+1).
  localparam int unsigned E_BIG  = 127 + W;

  localparam logic [1:0] RM_RTZ = 2'b00;
  localparam logic [1:0] RM_RDN = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RNE = 2'b11;

  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] UMAX = {W{1'b1}};

  // Global advance: every stage moves together or holds together.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: decode and classify ----------------
  logic [7:0]       d_e;
  logic [22:0]      d_m;
  assign d_e = in_x[30:23];
  assign d_m = in_x[22:0];

  logic             s1_v, s1_s, s1_zero, s1_nan, s1_inf, s1_tiny, s1_big, s1_uns;
  logic [22:0]      s1_m;
  logic [SHW-1:0]   s1_sh;
  logic [1:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else if (adv) begin
      s1_v    <= in_valid;
      s1_s    <= in_x[31];
      s1_m    <= d_m;
      s1_zero <= (d_e == 8'd0);
      s1_nan  <= (d_e == 8'hFF) && (d_m != 23'd0);
      s1_inf  <= (d_e == 8'hFF) && (d_m == 23'd0);
      s1_tiny <= (d_e < 8'(E_LO));
      s1_big  <= ({1'b0, d_e} >= 9'(E_BIG));
      s1_sh   <= SHW'(d_e - 8'(E_LO));
      s1_rm   <= in_rm;
      s1_uns  <= in_uns;
      s1_tag  <= in_tag;
    end
  end

  // ---------------- S2: align into integer part + guard + sticky ----------------
  logic [VW-1:0] sv;
  assign sv = VW'({1'b1, s1_m}) << s1_sh;

  logic             s2_v, s2_s, s2_g, s2_st, s2_zero, s2_nan, s2_ovf, s2_uns;
  logic [W-1:0]     s2_ip;
  logic [1:0]       s2_rm;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
    end else if (adv) begin
      s2_v    <= s1_v;
      s2_s    <= s1_s;
      s2_zero <= s1_zero;
      s2_nan  <= s1_nan;
      s2_ovf  <= s1_inf || s1_big;
      s2_rm   <= s1_rm;
      s2_uns  <= s1_uns;
      s2_tag  <= s1_tag;
      if (s1_tiny) begin
        // |x| < 0.5: only sticky survives.
        s2_ip <= '0;
        s2_g  <= 1'b0;
        s2_st <= 1'b1;
      end else begin
        s2_ip <= sv[VW-1:24];
        s2_g  <= sv[23];
        s2_st <= |sv[22:0];
      end
    end
  end

  // ---------------- S3: round, negate, saturate ----------------
  logic           inc;
  logic [W:0]     mag;
  logic           lost;
  logic [W-1:0]   y_c;
  logic           nx_c, nv_c;

  assign lost = s2_g | s2_st;

  // Rounding increment on the magnitude.
  always_comb begin
    inc = 1'b0;
    case (s2_rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s2_s & lost;
      RM_RUP:  inc = ~s2_s & lost;
      RM_RNE:  inc = s2_g & (s2_st | s2_ip[0]);
      default: inc = 1'b0;
    endcase
  end

  // Extra top bit catches a rounding carry out of the W-bit magnitude.
  assign mag = {1'b0, s2_ip} + (W+1)'(inc);

  always_comb begin
    y_c  = '0;
    nx_c = 1'b0;
    nv_c = 1'b0;
    if (!s2_zero) begin
      if (s2_nan) begin
        y_c  = s2_uns ? UMAX : SMAX;
        nv_c = 1'b1;
      end else if (s2_ovf || mag[W]) begin
        nv_c = 1'b1;
        if (s2_s) y_c = s2_uns ? '0 : SMIN;
        else      y_c = s2_uns ? UMAX : SMAX;
      end else if (s2_uns) begin
        if (!s2_s) begin
          y_c  = mag[W-1:0];
          nx_c = lost;
        end else if (mag[W-1:0] == '0) begin
          nx_c = lost;
        end else begin
          nv_c = 1'b1;
        end
      end else if (!s2_s) begin
        if (mag[W-1:0] > SMAX) begin
          y_c  = SMAX;
          nv_c = 1'b1;
        end else begin
          y_c  = mag[W-1:0];
          nx_c = lost;
        end
      end else begin
        if (mag[W-1:0] > SMIN) begin
          y_c  = SMIN;
          nv_c = 1'b1;
        end else begin
          y_c  = W'(~mag[W-1:0] + W'(1));
          nx_c = lost;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
      out_nx    <= 1'b0;
      out_nv    <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_v;
      out_y     <= y_c;
      out_tag   <= s2_tag;
      out_nx    <= nx_c;
      out_nv    <= nv_c;
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe: scoreboard bench for ftoi_pipe (W=32, TAG_W=5).
module tb_ftoi_pipe;
  localparam int unsigned W     = 32;
  localparam int unsigned TAG_W = 5;

  localparam logic [1:0] RTZ = 2'b00;
  localparam logic [1:0] RDN = 2'b01;
  localparam logic [1:0] RUP = 2'b10;
  localparam logic [1:0] RNE = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_uns;
  logic [31:0]      in_x;
  logic [1:0]       in_rm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_nx, out_nv;
  logic [W-1:0]     out_y;
  logic [TAG_W-1:0] out_tag;

  ftoi_pipe #(.W(W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_rm(in_rm),
    .in_uns(in_uns), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_tag(out_tag), .out_nx(out_nx), .out_nv(out_nv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  x;
    logic [1:0]   rm;
    logic         uns;
    logic [W-1:0] y;
    logic         nx;
    logic         nv;
    int           id;
  } vec_t;

  typedef struct {
    logic [W-1:0]     y;
    logic [TAG_W-1:0] tag;
    logic             nx;
    logic             nv;
    int               id;
  } exp_t;

  vec_t             stim_q[$];
  exp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               vid   = 0;
  logic [TAG_W-1:0] tag_ctr = '0;

  task automatic add(input logic [31:0] x, input logic [1:0] rm, input logic uns,
                     input logic [W-1:0] y, input logic nx, input logic nv);
    vec_t v;
    v.x = x; v.rm = rm; v.uns = uns; v.y = y; v.nx = nx; v.nv = nv; v.id = vid;
    vid++;
    stim_q.push_back(v);
  endtask

  // Drives queued operands, pushes expectations on accept, pops and compares on output.
  task automatic stream(input bit rnd, output int ncyc, output int acc0, output int out0);
    exp_t e;
    bit stalled = 1'b0;
    logic [W+TAG_W+2:0] held = '0;
    logic [W+TAG_W+2:0] now_o;
    ncyc = 0; acc0 = -1; out0 = -1;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && ncyc < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stim_q.size() != 0) begin
        in_valid = 1'b1;
        in_x     = stim_q[0].x;
        in_rm    = stim_q[0].rm;
        in_uns   = stim_q[0].uns;
        in_tag   = tag_ctr;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      now_o = {out_valid, out_y, out_tag, out_nx, out_nv};
      if (out_valid && out0 < 0) out0 = ncyc;
      if (stalled) begin
        n_cmp++;
        if (now_o !== held) begin
          n_bad++;
          $display("FAIL stall_hold: outputs %h required held %h", now_o, held);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL extra_result: y=%h tag=%h got, nothing expected", out_y, out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({out_y, out_tag, out_nx, out_nv} !== {e.y, e.tag, e.nx, e.nv}) begin
            n_bad++;
            $display("FAIL vec%0d: y=%h tag=%h nx=%b nv=%b, required y=%h tag=%h nx=%b nv=%b",
                     e.id, out_y, out_tag, out_nx, out_nv, e.y, e.tag, e.nx, e.nv);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = now_o;
      if (in_valid && in_ready) begin
        e.y = stim_q[0].y; e.nx = stim_q[0].nx; e.nv = stim_q[0].nv;
        e.id = stim_q[0].id; e.tag = tag_ctr;
        exp_q.push_back(e);
        void'(stim_q.pop_front());
        tag_ctr = tag_ctr + 1'b1;
        if (acc0 < 0) acc0 = ncyc;
      end
      @(posedge clk); #1;
      ncyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (stim_q.size() != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_timeout: %0d unsent, %0d unreturned, required 0/0",
               stim_q.size(), exp_q.size());
      stim_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_rm = RTZ; in_uns = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_y, out_tag, out_nx, out_nv} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: v=%b y=%h tag=%h nx=%b nv=%b, required all 0",
               out_valid, out_y, out_tag, out_nx, out_nv);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: %b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rounding();
    int nc, a0, o0;
    add(32'h40200000, RTZ, 1'b0, 32'd2, 1'b1, 1'b0);
    add(32'h40200000, RDN, 1'b0, 32'd2, 1'b1, 1'b0);
    add(32'h40200000, RUP, 1'b0, 32'd3, 1'b1, 1'b0);
    add(32'h40200000, RNE, 1'b0, 32'd2, 1'b1, 1'b0);
    add(32'hC0200000, RTZ, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
    add(32'hC0200000, RDN, 1'b0, 32'hFFFFFFFD, 1'b1, 1'b0);
    add(32'hC0200000, RUP, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
    add(32'hC0200000, RNE, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
    stream(1'b0, nc, a0, o0);
    n_cmp++;
    if (o0 - a0 != 3) begin
      n_bad++;
      $display("FAIL latency_ready_high: %0d cycles, required 3", o0 - a0);
    end
    n_cmp++;
    if (nc != 11) begin
      n_bad++;
      $display("FAIL throughput: 8 ops took %0d cycles, required 11", nc);
    end
  endtask

  task automatic test_rne_exact();
    int nc, a0, o0;
    add(32'h40600000, RNE, 1'b0, 32'd4, 1'b1, 1'b0);
    add(32'h3F000000, RNE, 1'b0, 32'd0, 1'b1, 1'b0);
    add(32'h3F800000, RNE, 1'b0, 32'd1, 1'b0, 1'b0);
    add(32'h3FC00000, RTZ, 1'b0, 32'd1, 1'b1, 1'b0);
    add(32'h3E99999A, RUP, 1'b0, 32'd1, 1'b1, 1'b0);
    stream(1'b0, nc, a0, o0);
  endtask

  task automatic test_range_signed();
    int nc, a0, o0;
    add(32'h4F000000, RTZ, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    add(32'hCF000000, RNE, 1'b0, 32'h80000000, 1'b0, 1'b0);
    add(32'hCF000001, RTZ, 1'b0, 32'h80000000, 1'b0, 1'b1);
    add(32'h7FC00000, RTZ, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    add(32'hFFC00000, RDN, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    add(32'h00000001, RUP, 1'b0, 32'd0, 1'b0, 1'b0);
    add(32'h80000001, RDN, 1'b0, 32'd0, 1'b0, 1'b0);
    add(32'hFF800000, RTZ, 1'b0, 32'h80000000, 1'b0, 1'b1);
    add(32'h5F800000, RNE, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    stream(1'b0, nc, a0, o0);
  endtask

  task automatic test_unsigned();
    int nc, a0, o0;
    add(32'h4F000000, RTZ, 1'b1, 32'h80000000, 1'b0, 1'b0);
    add(32'hBF800000, RTZ, 1'b1, 32'd0, 1'b0, 1'b1);
    add(32'hBE99999A, RTZ, 1'b1, 32'd0, 1'b1, 1'b0);
    add(32'h4F800000, RTZ, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    add(32'h7F800000, RNE, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    add(32'hFF800000, RNE, 1'b1, 32'd0, 1'b0, 1'b1);
    add(32'h7FC00000, RTZ, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    add(32'h4F7FFFFF, RTZ, 1'b1, 32'hFFFFFF00, 1'b0, 1'b0);
    add(32'h80000000, RDN, 1'b1, 32'd0, 1'b0, 1'b0);
    stream(1'b0, nc, a0, o0);
  endtask

  task automatic test_back_to_back();
    int nc, a0, o0;
    add(32'h40200000, RUP, 1'b0, 32'd3, 1'b1, 1'b0);
    add(32'hC0200000, RDN, 1'b0, 32'hFFFFFFFD, 1'b1, 1'b0);
    add(32'h40600000, RNE, 1'b0, 32'd4, 1'b1, 1'b0);
    add(32'h3F800000, RTZ, 1'b0, 32'd1, 1'b0, 1'b0);
    add(32'h4F000000, RTZ, 1'b1, 32'h80000000, 1'b0, 1'b0);
    add(32'hBF800000, RTZ, 1'b1, 32'd0, 1'b0, 1'b1);
    add(32'h7FC00000, RNE, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    add(32'h42F70000, RTZ, 1'b0, 32'd123, 1'b1, 1'b0);
    stream(1'b1, nc, a0, o0);
    n_cmp++;
    if (o0 - a0 != 3) begin
      n_bad++;
      $display("FAIL latency_first: %0d cycles, required 3", o0 - a0);
    end
  endtask

  task automatic test_reset_in_flight();
    int seen = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = 32'h3F800000; in_rm = RTZ; in_uns = 1'b0;
      in_tag = TAG_W'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL flight_fill: out_valid=%b, required 1", out_valid);
    end
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, out_y, out_tag, out_nx, out_nv} !== '0) begin
      n_bad++;
      $display("FAIL flight_reset: v=%b y=%h tag=%h, required all 0", out_valid, out_y, out_tag);
    end
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL flight_stale: %0d stale results, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_rne_exact();
    test_range_signed();
    test_unsigned();
    test_back_to_back();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
